// File: rtl/spike_window_decoder.sv
// spike_window_decoder
// Classification readout for the two-layer spiking network. Counts spikes of
// the three output neurons over a programmable window of L clock cycles and
// publishes the three counts plus the argmax neuron through a valid/ready
// result port. An unconsumed result that gets overwritten raises a sticky
// overrun flag.
module spike_window_decoder #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       spikes_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic             result_ready,
  input  logic             clr_overrun,
  output logic             result_valid,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2,
  output logic [1:0]       winner,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [1:0]       NO_WINNER = 2'b11;

  state_t           state_q;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] tick_q;
  logic             valid_q;
  logic             overrun_q;
  logic [1:0]       winner_q;
  logic [1:0]       winner_d;

  logic [CNT_W-1:0] acc_q   [3];
  logic [CNT_W-1:0] acc_d   [3];
  logic [CNT_W-1:0] count_q [3];

  logic [WIN_W-1:0] len_eff;
  logic             counting;
  logic             win_end;

  // A window length of zero behaves like a one-cycle window.
  assign len_eff  = (window_len == '0) ? WIN_ONE : window_len;
  assign counting = (state_q == S_COUNT);
  // The L-th counting edge closes the window, regardless of enable.
  assign win_end  = counting && (tick_q == (len_q - WIN_ONE));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_neuron
      // Saturating increment of this neuron's accumulator.
      assign acc_d[gi] = (spikes_in[gi] && (acc_q[gi] != CNT_MAX))
                         ? (acc_q[gi] + CNT_ONE) : acc_q[gi];

      // Accumulate while counting; clear at window end, on abort and in IDLE.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_q[gi] <= '0;
        end else if (counting && enable && !win_end) begin
          acc_q[gi] <= acc_d[gi];
        end else begin
          acc_q[gi] <= '0;
        end
      end

      // Publish the count at window end, including this edge's spike.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_q[gi] <= '0;
        end else if (win_end) begin
          count_q[gi] <= acc_d[gi];
        end
      end
    end
  endgenerate

  // Argmax over the closing counts; the lowest index wins ties and an empty
  // window reports no winner.
  always_comb begin
    winner_d = NO_WINNER;
    if ((acc_d[0] == '0) && (acc_d[1] == '0) && (acc_d[2] == '0)) begin
      winner_d = NO_WINNER;
    end else if ((acc_d[0] >= acc_d[1]) && (acc_d[0] >= acc_d[2])) begin
      winner_d = 2'd0;
    end else if (acc_d[1] >= acc_d[2]) begin
      winner_d = 2'd1;
    end else begin
      winner_d = 2'd2;
    end
  end

  // Window controller: state, window length, tick, and the result port flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= WIN_ONE;
      tick_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      winner_q  <= NO_WINNER;
    end else begin
      case (state_q)
        S_IDLE: begin
          tick_q <= '0;
          if (enable) begin
            len_q   <= len_eff;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (win_end) begin
            tick_q  <= '0;
            len_q   <= len_eff;
            state_q <= enable ? S_COUNT : S_IDLE;
          end else if (!enable) begin
            tick_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            tick_q <= tick_q + WIN_ONE;
          end
        end
        default: begin
          tick_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase

      // A new result always lands; otherwise a handshake empties the port.
      if (win_end) begin
        valid_q  <= 1'b1;
        winner_q <= winner_d;
      end else if (valid_q && result_ready) begin
        valid_q <= 1'b0;
      end

      // Sticky overrun: setting takes priority over the clear request.
      if (win_end && valid_q && !result_ready) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign result_valid = valid_q;
  assign count0       = count_q[0];
  assign count1       = count_q[1];
  assign count2       = count_q[2];
  assign winner       = winner_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == S_COUNT);

endmodule

// File: tb/tb_spike_window_decoder.sv
// Testbench for spike_window_decoder: directed scenarios followed by random
// traffic, checked through a result scoreboard fed by a window-level model.
module tb_spike_window_decoder;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0] c0;
    logic [CNT_W-1:0] c1;
    logic [CNT_W-1:0] c2;
    logic [1:0]       w;
  } res_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       spikes_in = '0;
  logic             enable = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic             result_ready = 1'b0;
  logic             clr_overrun = 1'b0;
  logic             result_valid;
  logic [CNT_W-1:0] count0, count1, count2;
  logic [1:0]       winner;
  logic             overrun;
  logic             busy;

  spike_window_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .spikes_in(spikes_in), .enable(enable),
    .window_len(window_len), .result_ready(result_ready),
    .clr_overrun(clr_overrun), .result_valid(result_valid),
    .count0(count0), .count1(count1), .count2(count2), .winner(winner),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard and window-level reference state.
  res_t       exp_q[$];
  bit         m_active = 0;
  int         m_len = 1;
  logic [2:0] m_spk[$];
  bit         m_ovr = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts are the number of spikes per neuron in the window, clipped at the
  // counter maximum; the winner is the first neuron holding the strictly
  // largest nonzero count.
  function automatic res_t ref_result();
    int c[3];
    int best;
    int bestv;
    res_t r;
    c = '{0, 0, 0};
    foreach (m_spk[k])
      for (int i = 0; i < 3; i++)
        if (m_spk[k][i]) c[i]++;
    for (int i = 0; i < 3; i++)
      if (c[i] > CMAX) c[i] = CMAX;
    best = 3;
    bestv = 0;
    for (int i = 0; i < 3; i++)
      if (c[i] > bestv) begin
        best = i;
        bestv = c[i];
      end
    r.c0 = c[0][CNT_W-1:0];
    r.c1 = c[1][CNT_W-1:0];
    r.c2 = c[2][CNT_W-1:0];
    r.w  = best[1:0];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit   pending;
    bit   wend;
    res_t r;
    pending = (exp_q.size() > 0);
    wend = 0;
    r = '0;
    if (reset) begin
      m_active = 0;
      m_spk.delete();
      exp_q.delete();
      m_ovr = 0;
      return;
    end
    if (!m_active) begin
      if (enable) begin
        m_active = 1;
        m_len = (window_len == 0) ? 1 : int'(window_len);
        m_spk.delete();
      end
    end else begin
      m_spk.push_back(spikes_in);
      if (m_spk.size() == m_len) begin
        wend = 1;
        r = ref_result();
        m_spk.delete();
        if (enable) m_len = (window_len == 0) ? 1 : int'(window_len);
        else m_active = 0;
      end else if (!enable) begin
        m_active = 0;
        m_spk.delete();
      end
    end
    if (wend) begin
      if (pending && !result_ready) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      exp_q.delete();
      exp_q.push_back(r);
    end else begin
      if (pending && result_ready) void'(exp_q.pop_front());
      if (clr_overrun) m_ovr = 0;
    end
  endtask

  task automatic step(input logic [2:0] spk, input logic en, input logic rdy,
                      input logic clr, input int wl);
    spikes_in    = spk;
    enable       = en;
    result_ready = rdy;
    clr_overrun  = clr;
    window_len   = wl[WIN_W-1:0];
    model_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every edge compare flags, and the presented result against
  // the scoreboard head whenever the DUT shows a valid result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy", busy, m_active);
      chk("overrun", overrun, m_ovr);
      chk("result_valid", result_valid, exp_q.size() > 0);
      if (result_valid && exp_q.size() > 0)
        chk("result", {count0, count1, count2, winner}, exp_q[0]);
    end
  end

  initial begin
    // Power-on reset.
    step(3'b000, 0, 0, 0, 4);
    step(3'b000, 0, 0, 0, 4);
    reset = 1'b0;
    step(3'b000, 0, 0, 0, 4);

    // Basic window, L = 4.
    step(3'b111, 1, 0, 0, 4);
    step(3'b001, 1, 0, 0, 4);
    step(3'b011, 1, 0, 0, 4);
    step(3'b001, 1, 0, 0, 4);
    step(3'b100, 0, 0, 0, 4);
    chk("basic_valid", result_valid, 1);
    chk("basic_counts", {count0, count1, count2}, {8'd3, 8'd1, 8'd1});
    chk("basic_winner", winner, 2'd0);
    step(3'b000, 0, 1, 0, 4);

    // Tie, then an empty back-to-back window.
    step(3'b000, 1, 0, 0, 2);
    step(3'b110, 1, 0, 0, 2);
    step(3'b110, 1, 0, 0, 2);
    chk("tie_counts", {count0, count1, count2}, {8'd0, 8'd2, 8'd2});
    chk("tie_winner", winner, 2'd1);
    step(3'b000, 1, 1, 0, 2);
    step(3'b000, 0, 0, 0, 2);
    chk("empty_winner", winner, 2'b11);
    step(3'b000, 0, 1, 0, 2);

    // Saturation with L = 300, then L = 0 acting as one-cycle windows.
    step(3'b000, 1, 0, 0, 300);
    for (int i = 0; i < 299; i++) step(3'b100, 1, 0, 0, 300);
    step(3'b100, 0, 0, 0, 300);
    chk("sat_count2", count2, 8'd255);
    chk("sat_count0", count0, 8'd0);
    step(3'b000, 0, 1, 0, 300);
    step(3'b000, 1, 1, 0, 0);
    step(3'b010, 1, 1, 0, 0);
    step(3'b010, 1, 1, 0, 0);
    step(3'b010, 0, 1, 0, 0);
    chk("l0_valid", result_valid, 1);
    chk("l0_count1", count1, 8'd1);
    step(3'b000, 0, 1, 0, 0);

    // Handshake and overrun, L = 3 continuous.
    step(3'b000, 1, 0, 0, 3);
    for (int k = 1; k <= 8; k++) step(3'($urandom_range(7)), 1, 0, 0, 3);
    chk("ovr_set", overrun, 1);
    step(3'($urandom_range(7)), 1, 1, 0, 3);
    chk("ready_on_end_valid", result_valid, 1);
    step(3'b000, 0, 0, 1, 3);
    chk("ovr_clr", overrun, 0);
    step(3'b000, 0, 1, 0, 3);

    // Abort at tick 2 of an L = 5 window, then a fresh window.
    step(3'b000, 1, 0, 0, 5);
    step(3'b111, 1, 0, 0, 5);
    step(3'b111, 1, 0, 0, 5);
    step(3'b111, 0, 0, 0, 5);
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    step(3'b000, 1, 0, 0, 5);
    for (int k = 0; k < 4; k++) step(3'b010, 1, 0, 0, 5);
    step(3'b010, 0, 0, 0, 5);
    chk("reen_counts", {count0, count1, count2}, {8'd0, 8'd5, 8'd0});

    // Reset mid-COUNT with a result pending and overrun set.
    step(3'b001, 1, 0, 0, 2);
    for (int k = 0; k < 5; k++) step(3'b001, 1, 0, 0, 2);
    reset = 1'b1;
    model_edge();
    #1;
    chk("rst_valid", result_valid, 0);
    chk("rst_counts", {count0, count1, count2}, 24'd0);
    chk("rst_winner", winner, 2'b11);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    step(3'b000, 1, 0, 0, 2);
    reset = 1'b0;
    step(3'b011, 0, 0, 0, 2);
    step(3'b011, 0, 0, 0, 2);
    chk("post_rst_busy", busy, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step(3'($urandom_range(7)),
           ($urandom_range(15) != 0),
           ($urandom_range(3) == 0),
           ($urandom_range(31) == 0),
           int'($urandom_range(6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
